apb_fifo_sched: RTL and testbench
=================================

# apb_fifo_sched

Multi-requester APB master scheduler for the APB byte-FIFO slave. Accepts single-byte write (push) and read (pop) requests from `NREQ` local clients and grants them round-robin. Runs each granted request as one APB SETUP/ACCESS transfer, applying the slave's PADDR encoding (0 = write port, 1 = read port). Returns per-transfer status, read data and error to the issuing client, plus a saturating error counter.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 15: max ACCESS cycles waiting for completion before forced error, ≥1.
- `PCLK`  in  1  clock; one clock domain. All signals are sampled on the rising edge.
- `PRESET`  in  1  reset; synchronous, active-high.
- `req_valid`  in  NREQ  request pending per client; held until `req_ready`.
- `req_write`  in  NREQ  1 = push byte, 0 = pop byte.
- `req_wdata`  in  8*NREQ  push data, client i at bits [8i+7:8i].
- `req_ready`  out  NREQ  one-hot, one-cycle accept pulse.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_id`  out  $clog2(NREQ)  client index of completed transfer.
- `rsp_err`  out  1  PSLVERR seen or timeout.
- `rsp_rdata`  out  8  PRDATA captured on pop; 0 on push.
- `err_cnt`  out  16  saturating count of `rsp_err` completions.
- `PSELx`, `PENABLE`, `PADDR`, `PWRITE`  out  1  APB control toward the FIFO slave.
- `PWDATA`  out  8  APB write data.
- `PREADY`, `PSLVERR`  in  1  APB slave response.
- `PRDATA`  in  8  APB read data.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- **IDLE.** If any `req_valid` is set, the arbiter picks winner g and pulses `req_ready[g]`. It latches g, `req_write[g]` and `req_wdata[g]`, then moves to SETUP. With no request it stays in IDLE.
- **SETUP.** `PSELx`=1, `PENABLE`=0. Drives `PADDR` = !write, `PWRITE` = write, `PWDATA` = latched data (0 on pop). Unconditionally moves to ACCESS.
- **ACCESS.** `PSELx`=1, `PENABLE`=1, address/data held stable. The transfer completes on the first cycle where `PREADY`|`PSLVERR` is set, or when the wait counter reaches `TIMEOUT`. On completion the FSM moves to IDLE.
- PSLVERR counts as a completion because the slave holds PREADY low while erroring.
- **Completion (registered, next cycle).**
  - `rsp_valid`=1, `rsp_id`=g.
  - `rsp_err` = PSLVERR | timeout.
  - `rsp_rdata` = PRDATA on a clean pop, else 0.
  - `err_cnt` increments on error and saturates at 0xFFFF.
- **Round-robin.** Search starts at index (last_grant+1) mod NREQ. After reset last_grant = NREQ-1, so client 0 has first priority. The pointer updates only on grant.
- **Wait counter.** Width $clog2(TIMEOUT+1). Cleared on entering ACCESS, incremented each ACCESS cycle without completion.
- **Reset values.** All outputs 0, state IDLE, err_cnt 0.
- **Reset mid-transfer.** The FSM returns to IDLE on the next edge and no `rsp_valid` is issued for the aborted transfer. The client must re-request.

## Timing
- **Minimum latency.** Accept at cycle 0, SETUP at 1, ACCESS at 2 (PREADY same cycle), `rsp_valid` at 3.
- **Throughput.** IDLE may grant in the same cycle `rsp_valid` is high, giving one transfer per 3 cycles.
- **Client stability.** Clients must keep `req_valid`/`req_write`/`req_wdata` stable until `req_ready`. Deasserting `req_valid` before grant withdraws the request without side effects.
- **Grant timing.** Simultaneous requests give exactly one grant per IDLE cycle. No client waits more than NREQ-1 grants.
- **Timeout.** Completion with `rsp_err`=1 occurs when the counter reaches TIMEOUT, i.e. after TIMEOUT+1 ACCESS cycles. PSELx/PENABLE drop the following cycle.
- **Interleaving.** Pushes and pops from different clients interleave freely; FIFO ordering is the slave's responsibility.

## Structure
- **Package `apb_fifo_pkg`.**
  - state enum `sched_state_t` {IDLE, SETUP, ACCESS}.
  - constants `ADDR_WR`=1'b0, `ADDR_RD`=1'b1.
  - `DATA_W`=8, `ERRCNT_W`=16.
- **Sub-module `rr_arbiter`.** Parameterised NREQ. Inputs: req vector, enable. Outputs: one-hot grant and grant index. Holds the last_grant pointer.
- **Top level.** Holds the FSM, request latch, wait counter, response registers and err_cnt.

## Test plan
- **Single push.** Client 1 pushes 0xA5 with PREADY=1 in ACCESS. Expect `req_ready[1]` at cycle 0, SETUP with PADDR=0/PWRITE=1/PWDATA=0xA5 at cycle 1, `rsp_valid` at cycle 3 with id=1, err=0, rdata=0.
- **Pop.** Client 2 pops with PRDATA=0x3C and PREADY=1. Expect PADDR=1, PWRITE=0, `rsp_rdata`=0x3C, `rsp_err`=0.
- **Fairness.** All 4 clients hold `req_valid` continuously from reset. Expect grant order 0,1,2,3,0, one grant every 3 cycles.
- **Slave error.** PSLVERR=1 with PREADY=0 in ACCESS (full FIFO push). Expect completion that cycle, `rsp_err`=1, `err_cnt` 0→1.
- **Timeout.** PREADY=PSLVERR=0 forever with TIMEOUT=15. Expect ACCESS held 16 cycles, then `rsp_err`=1. The next grant proceeds normally.
- **Reset mid-ACCESS.** PRESET=1 for one cycle during ACCESS. Expect all outputs 0 next cycle, no `rsp_valid`, and client 0 granted first after release.

Source files
------------

// File: rtl/apb_fifo_pkg.sv
// Shared types and constants for the APB byte-FIFO master scheduler.
package apb_fifo_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ERRCNT_W = 16;

    // Slave address map: port 0 accepts pushes, port 1 serves pops.
    localparam logic ADDR_WR = 1'b0;
    localparam logic ADDR_RD = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } sched_state_t;

    // Command presented on the APB address/data lines for one transfer.
    typedef struct packed {
        logic              paddr;
        logic              pwrite;
        logic [DATA_W-1:0] pwdata;
    } apb_cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered last-grant pointer.
// Ports: clk_i/rst_i (sync active-high), req_i request vector, en_i grant enable,
//        gnt_o one-hot grant, gnt_idx_o grant index, gnt_valid_o a grant is issued.
module rr_arbiter #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NREQ-1:0] req_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  gnt_idx_o,
    output logic            gnt_valid_o
);

    logic [IDW-1:0] last_q, last_d;
    logic [IDW-1:0] idx;
    logic           found;

    // Search starts one past the previous winner and wraps around.
    always_comb begin
        found     = 1'b0;
        idx       = '0;
        gnt_idx_o = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = IDW'((32'(last_q) + i) % NREQ);
            if (!found && req_i[idx]) begin
                found     = 1'b1;
                gnt_idx_o = idx;
            end
        end
        gnt_valid_o = en_i & found;
        gnt_o       = gnt_valid_o ? (NREQ'(1) << gnt_idx_o) : '0;
        last_d      = gnt_valid_o ? gnt_idx_o : last_q;
    end

    // Pointer resets to the last client so client 0 wins first.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= IDW'(NREQ - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/apb_fifo_sched.sv
// APB master scheduler: grants client push/pop requests round-robin and runs each
// as one SETUP/ACCESS transfer toward the byte-FIFO slave.
// Ports: PCLK/PRESET (sync active-high); req_* client request side, req_ready
//        combinational accept pulse; rsp_* registered completion; err_cnt
//        saturating error count; P* APB master signals.
module apb_fifo_sched
    import apb_fifo_pkg::*;
#(
    parameter  int unsigned NREQ    = 4,
    parameter  int unsigned TIMEOUT = 15,
    localparam int unsigned IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_write,
    input  logic [DATA_W*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]        req_ready,
    output logic                   rsp_valid,
    output logic [IDW-1:0]         rsp_id,
    output logic                   rsp_err,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic [ERRCNT_W-1:0]    err_cnt,
    output logic                   PSELx,
    output logic                   PENABLE,
    output logic                   PADDR,
    output logic                   PWRITE,
    output logic [DATA_W-1:0]      PWDATA,
    input  logic                   PREADY,
    input  logic                   PSLVERR,
    input  logic [DATA_W-1:0]      PRDATA
);

    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    sched_state_t          state_q, state_d;
    logic [IDW-1:0]        id_q, id_d;
    apb_cmd_t              cmd_q, cmd_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic [WW-1:0]         wait_q, wait_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]        rsp_id_q, rsp_id_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic [ERRCNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic                  gnt_valid;
    logic [IDW-1:0]        gnt_idx;
    logic                  timed_out_c;
    logic                  done_c;
    logic [DATA_W-1:0]     wdata_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    end

    // Grants only in IDLE and never while reset is asserted.
    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk_i       (PCLK),
        .rst_i       (PRESET),
        .req_i       (req_valid),
        .en_i        ((state_q == IDLE) && !PRESET),
        .gnt_o       (req_ready),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        cmd_d       = cmd_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        wait_d      = wait_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = '0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        err_cnt_d   = err_cnt_q;
        timed_out_c = 1'b0;
        done_c      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d      = SETUP;
                    id_d         = gnt_idx;
                    psel_d       = 1'b1;
                    cmd_d.pwrite = req_write[gnt_idx];
                    cmd_d.paddr  = req_write[gnt_idx] ? ADDR_WR : ADDR_RD;
                    cmd_d.pwdata = req_write[gnt_idx] ? wdata_arr[gnt_idx] : '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                wait_d    = '0;
            end
            ACCESS: begin
                // PSLVERR completes on its own since the slave keeps PREADY low.
                timed_out_c = (wait_q == WW'(TIMEOUT)) && !PREADY && !PSLVERR;
                done_c      = PREADY | PSLVERR | timed_out_c;
                if (done_c) begin
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    cmd_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_err_d   = PSLVERR | timed_out_c;
                    rsp_rdata_d = (!cmd_q.pwrite && !rsp_err_d) ? PRDATA : '0;
                    if (rsp_err_d && (err_cnt_q != '1)) begin
                        err_cnt_d = err_cnt_q + ERRCNT_W'(1);
                    end
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any transfer silently.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            id_q        <= '0;
            cmd_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            wait_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            cmd_q       <= cmd_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            wait_q      <= wait_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign PSELx     = psel_q;
    assign PENABLE   = penable_q;
    assign PADDR     = cmd_q.paddr;
    assign PWRITE    = cmd_q.pwrite;
    assign PWDATA    = cmd_q.pwdata;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_apb_fifo_sched.sv
// Bench for apb_fifo_sched: transaction-level model checked every cycle plus
// directed scenarios with literal expectations.
module tb_apb_fifo_sched;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 15;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [3:0]  req_valid, req_write, req_ready;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_err;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_rdata, PWDATA, PRDATA;
    logic [15:0] err_cnt;
    logic        PSELx, PENABLE, PADDR, PWRITE, PREADY, PSLVERR;

    always #5 PCLK = ~PCLK;

    apb_fifo_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_write(req_write), .req_wdata(req_wdata),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .rsp_rdata(rsp_rdata), .err_cnt(err_cnt),
        .PSELx(PSELx), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (last + k) % NREQ;
            if (|(v & (4'(1) << idx))) return idx;
        end
        return -1;
    endfunction

    // Model: phase 0 = no transfer, 1 = first transfer cycle, 2 = waiting for slave.
    bit         m_init = 1'b0;
    int         m_phase = 0, m_last = NREQ - 1, m_id = 0, m_acc = 0, m_errcnt = 0;
    bit         m_wr = 1'b0;
    logic [7:0] m_data = 8'h00;
    bit         m_rv = 1'b0, m_rerr = 1'b0, m_to = 1'b0;
    int         m_rid = 0;
    logic [7:0] m_rdata = 8'h00;
    int         glog[$];
    int         gcyc[$];

    always @(posedge PCLK) begin
        int w;
        cyc++;
        if (PRESET) begin
            m_init = 1'b1; m_phase = 0; m_last = NREQ - 1; m_rv = 1'b0; m_errcnt = 0;
        end else if (m_init) begin
            m_rv = 1'b0;
            if (m_phase == 0) begin
                w = rr_pick(req_valid, m_last);
                if (w >= 0) begin
                    m_last = w; m_id = w; m_phase = 1;
                    m_wr   = |(req_write & (4'(1) << w));
                    m_data = 8'(req_wdata >> (8 * w));
                end
            end else if (m_phase == 1) begin
                m_phase = 2; m_acc = 0;
            end else begin
                m_acc++;
                if (PREADY || PSLVERR || m_acc == TIMEOUT + 1) begin
                    m_to    = !PREADY && !PSLVERR;
                    m_rv    = 1'b1;
                    m_rid   = m_id;
                    m_rerr  = PSLVERR || m_to;
                    m_rdata = (!m_wr && !m_rerr) ? PRDATA : 8'h00;
                    if (m_rerr && m_errcnt < 65535) m_errcnt++;
                    m_phase = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge PCLK) begin
        int w;
        logic [3:0] exp_rdy;
        if (m_init) begin
            exp_rdy = 4'b0;
            if (m_phase == 0 && !PRESET) begin
                w = rr_pick(req_valid, m_last);
                if (w >= 0) exp_rdy = 4'(1) << w;
            end
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("PSELx", 32'(PSELx), 32'(m_phase != 0));
            chk("PENABLE", 32'(PENABLE), 32'(m_phase == 2));
            chk("PADDR", 32'(PADDR), 32'(m_phase != 0 && !m_wr));
            chk("PWRITE", 32'(PWRITE), 32'(m_phase != 0 && m_wr));
            chk("PWDATA", 32'(PWDATA), 32'((m_phase != 0 && m_wr) ? m_data : 8'h00));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
            if (m_rv) begin
                chk("rsp_id", 32'(rsp_id), 32'(m_rid));
                chk("rsp_err", 32'(rsp_err), 32'(m_rerr));
                chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
            end
            chk("err_cnt", 32'(err_cnt), 32'(m_errcnt));
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready == 4'(1) << i) begin
                    glog.push_back(i);
                    gcyc.push_back(cyc);
                end
            end
        end
    end

    // One request from a single client; reports response and cycle counts.
    task automatic xfer(input int id, input bit wr, input logic [7:0] d, input int budget,
                        output int n, output int pen, output int rid, output bit rerr,
                        output logic [7:0] rdata);
        bit got;
        got = 1'b0; n = 0; pen = 0; rid = -1; rerr = 1'b0; rdata = 8'h00;
        @(posedge PCLK); #1;
        req_valid = 4'(1) << id;
        req_write = wr ? req_valid : 4'b0;
        req_wdata = 32'(d) << (8 * id);
        @(negedge PCLK);
        chk("x_ready", 32'(req_ready), 32'(4'(1) << id));
        @(posedge PCLK); #1;
        req_valid = 4'b0;
        @(negedge PCLK);
        chk("x_setup_psel", 32'(PSELx), 32'd1);
        chk("x_setup_pen", 32'(PENABLE), 32'd0);
        chk("x_setup_paddr", 32'(PADDR), 32'(!wr));
        chk("x_setup_pwrite", 32'(PWRITE), 32'(wr));
        chk("x_setup_pwdata", 32'(PWDATA), 32'(wr ? d : 8'h00));
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge PCLK);
            n++;
            if (PENABLE) pen++;
            if (rsp_valid) begin
                got = 1'b1; rid = 32'(rsp_id); rerr = rsp_err; rdata = rsp_rdata;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL x_rsp_wait: no rsp_valid within %0d cycles for client %0d", budget, id);
        end
    endtask

    int         n, pen, rid;
    bit         rerr;
    logic [7:0] rdata;
    int         exp_ord[5] = '{0, 1, 2, 3, 0};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        PRESET = 1'b1; req_valid = 4'b0; req_write = 4'b0; req_wdata = 32'h0;
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 8'h00;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        chk("rst_psel", 32'(PSELx), 32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;

        // Single push, minimum latency.
        PREADY = 1'b1;
        xfer(1, 1'b1, 8'hA5, 20, n, pen, rid, rerr, rdata);
        chk("push_latency", 32'(n), 32'd2);
        chk("push_access_cycles", 32'(pen), 32'd1);
        chk("push_id", 32'(rid), 32'd1);
        chk("push_err", 32'(rerr), 32'd0);
        chk("push_rdata", 32'(rdata), 32'h00);

        // Pop returns PRDATA.
        PRDATA = 8'h3C;
        xfer(2, 1'b0, 8'h00, 20, n, pen, rid, rerr, rdata);
        chk("pop_id", 32'(rid), 32'd2);
        chk("pop_err", 32'(rerr), 32'd0);
        chk("pop_rdata", 32'(rdata), 32'h3C);

        // Slave error completes without PREADY.
        PREADY = 1'b0; PSLVERR = 1'b1;
        xfer(3, 1'b1, 8'h77, 20, n, pen, rid, rerr, rdata);
        chk("slverr_latency", 32'(n), 32'd2);
        chk("slverr_err", 32'(rerr), 32'd1);
        chk("slverr_cnt", 32'(err_cnt), 32'd1);

        // Timeout after TIMEOUT+1 access cycles, then a normal transfer.
        PSLVERR = 1'b0;
        xfer(0, 1'b1, 8'h11, 60, n, pen, rid, rerr, rdata);
        chk("to_access_cycles", 32'(pen), 32'd16);
        chk("to_latency", 32'(n), 32'd17);
        chk("to_err", 32'(rerr), 32'd1);
        chk("to_cnt", 32'(err_cnt), 32'd2);
        PREADY = 1'b1;
        xfer(1, 1'b1, 8'h22, 20, n, pen, rid, rerr, rdata);
        chk("after_to_id", 32'(rid), 32'd1);
        chk("after_to_err", 32'(rerr), 32'd0);
        chk("after_to_cnt", 32'(err_cnt), 32'd2);

        // Reset while in ACCESS aborts silently; client 0 wins first afterwards.
        PREADY = 1'b0;
        @(posedge PCLK); #1;
        req_valid = 4'b0100; req_write = 4'b0100; req_wdata = 32'h0099_0000;
        @(negedge PCLK);
        chk("mid_ready", 32'(req_ready), 32'h4);
        @(posedge PCLK); #1;
        req_valid = 4'b0;
        for (int k = 0; k < 10 && !PENABLE; k++) @(negedge PCLK);
        chk("mid_in_access", 32'(PENABLE), 32'd1);
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0; PREADY = 1'b1;
        req_valid = 4'b1111; req_write = 4'b1111; req_wdata = 32'hD4C3B2A1;
        @(negedge PCLK);
        chk("mid_rst_psel", 32'(PSELx), 32'd0);
        chk("mid_rst_penable", 32'(PENABLE), 32'd0);
        chk("mid_rst_pwdata", 32'(PWDATA), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("mid_rst_first_grant", 32'(req_ready), 32'h1);
        @(posedge PCLK); #1;
        req_valid = 4'b0;
        rid = -1;
        for (int k = 0; k < 10 && rid < 0; k++) begin
            @(negedge PCLK);
            if (rsp_valid) rid = 32'(rsp_id);
        end
        chk("mid_rst_rsp_id", 32'(rid), 32'd0);

        // Fairness with all clients requesting from reset.
        @(posedge PCLK); #1;
        PRESET = 1'b1; PRDATA = 8'h5A;
        req_valid = 4'b1111; req_write = 4'b0101; req_wdata = 32'h44332211;
        repeat (2) @(posedge PCLK);
        #1 PRESET = 1'b0;
        glog.delete(); gcyc.delete();
        for (int k = 0; k < 40 && glog.size() < 5; k++) @(posedge PCLK);
        #1 req_valid = 4'b0;
        checks++;
        if (glog.size() < 5) begin
            failures++;
            $display("FAIL fair_grants: got %0d grants expected 5", glog.size());
        end else begin
            for (int k = 0; k < 5; k++) chk($sformatf("fair_order_%0d", k), 32'(glog[k]), 32'(exp_ord[k]));
            for (int k = 1; k < 5; k++) chk($sformatf("fair_gap_%0d", k), 32'(gcyc[k] - gcyc[k-1]), 32'd3);
        end
        repeat (8) @(posedge PCLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
